// File: rtl/board_pkg.sv
// Shared definitions for the board read path: cell encodings, select packing
// and the arbiter state encoding.
package board_pkg;

    localparam int SEL_W  = 8;
    localparam int CELL_W = 2;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
    localparam logic [CELL_W-1:0] CELL_BLACK = 2'b01;
    localparam logic [CELL_W-1:0] CELL_WHITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Board select layout: x in the upper nibble, y in the lower nibble.
    function automatic logic [SEL_W-1:0] xy_to_sel(input logic [3:0] x, input logic [3:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection for the board read arbiter.
// Define BOARD_ARB_FIXED_PRIO_EN to make the lowest-index requester always win.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    assign any = |req;

`ifdef BOARD_ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;

    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
    end
`else
    // Walk the ring backwards so the candidate nearest after last_owner is assigned last.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_owner) + k) % NUM_REQ]) winner = IDX_W'((int'(last_owner) + k) % NUM_REQ);
        end
    end
`endif

endmodule

// File: rtl/board_read_arbiter.sv
// Shares the combinational board read port between NUM_REQ requesters.
// Arbitration is round-robin unless BOARD_ARB_FIXED_PRIO_EN is defined.
module board_read_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int SEL_W   = board_pkg::SEL_W,
    parameter int CELL_W  = board_pkg::CELL_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*SEL_W-1:0] coord,
    output logic [SEL_W-1:0]         rd_select,
    input  logic [CELL_W-1:0]        rd_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [CELL_W-1:0]        rsp_data,
    output logic [1:0]               dbg_state
);
    import board_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: a requester holds req/coord until its one-cycle rsp_valid; in that
    // RESP cycle it drops req or presents the next coord (with lock to keep ownership).

    arb_state_t         state, state_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [IDX_W-1:0]   last_owner, last_owner_n;
    logic [SEL_W-1:0]   rd_select_n;
    logic [NUM_REQ-1:0] gnt_n, rsp_valid_n;
    logic [CELL_W-1:0]  rsp_data_n;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic               hold_lock;

    assign hold_lock = lock[owner] & req[owner];
    assign dbg_state = state;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (winner),
        .any        (any_req)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            rd_select  <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            rd_select  <= rd_select_n;
            gnt        <= gnt_n;
            rsp_valid  <= rsp_valid_n;
            rsp_data   <= rsp_data_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_req) state_n = ADDR;
            ADDR:    state_n = RESP;
            RESP:    state_n = hold_lock ? ADDR : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        owner_n      = owner;
        last_owner_n = last_owner;
        rd_select_n  = rd_select;
        gnt_n        = gnt;
        rsp_valid_n  = '0;
        rsp_data_n   = rsp_data;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (any_req) begin
                    owner_n      = winner;
                    last_owner_n = winner;
                    rd_select_n  = coord[SEL_W*int'(winner) +: SEL_W];
                    gnt_n        = NUM_REQ'(1) << winner;
                end
            end
            ADDR: begin
                rsp_data_n  = rd_data;
                rsp_valid_n = NUM_REQ'(1) << owner;
            end
            RESP: begin
                // A locked owner re-reads without arbitration; lock from others is ignored.
                if (hold_lock) rd_select_n = coord[SEL_W*int'(owner) +: SEL_W];
                else           gnt_n = '0;
            end
            default: ;
        endcase
    end

endmodule
